// File: rtl/riscalar_pkg.sv
// Shared types for the result-broadcast path.
//   ROB_IX_W    : default reorder-buffer index width (8-entry ROB)
//   cdb_entry_t : one completed result {rob_ix, value, dest}. The reorder
//                 buffer and the reservation stations use the same type.
package riscalar_pkg;

  localparam int ROB_IX_W = 3;

  typedef struct packed {
    logic [ROB_IX_W-1:0] rob_ix;
    logic signed [31:0]  value;
    logic signed [31:0]  dest;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Synchronous FIFO of cdb_entry_t. There is one FIFO for each result source.
//   clk_in    : clock
//   rst_in    : synchronous active-high reset; empties the FIFO
//   flush_in  : empties the FIFO; a push or pop on the same edge is dropped
//   push_in   : write data_in. The write is ignored when the FIFO is full.
//   pop_in    : drop the head entry. Ignored when the FIFO is empty.
//   data_in   : entry to write
//   data_out  : head entry. Valid only while empty_out is 0.
//   full_out  : count has reached DEPTH
//   empty_out : count is 0
// DEPTH must be a power of two, so the pointers wrap by natural overflow.
module cdb_src_fifo
  import riscalar_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       flush_in,
  input  logic       push_in,
  input  logic       pop_in,
  input  cdb_entry_t data_in,
  output cdb_entry_t data_out,
  output logic       full_out,
  output logic       empty_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  cdb_entry_t       mem_q [DEPTH];
  cdb_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_out  = (count_q == CNT_W'(DEPTH));
  assign empty_out = (count_q == '0);
  assign data_out  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // The full test uses the registered count, so a pop on a full FIFO
    // does not make room for a push on the same edge.
    push_ok  = push_in && !full_out;
    pop_ok   = pop_in && !empty_out;

    if (push_ok) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    // Storage needs no reset. An entry cannot be read before it is written.
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Producer side of the common data bus.
// Each functional unit pushes its completed result into its own FIFO
// through a valid/ready handshake. Every cycle, one non-empty FIFO is
// granted by round-robin. Its head entry goes to the registered CDB port,
// which feeds the ROB and the reservation stations.
//   clk_in         : clock
//   rst_in         : synchronous active-high reset. Clears the CDB data registers.
//   flush_in       : drops every buffered result and any grant on the same edge
//   src_valid_in   : per-source result valid
//   src_ready_out  : per-source FIFO has space. Derived from registered state only.
//   src_rob_ix_in  : per-source ROB tag
//   src_value_in   : per-source result value
//   src_dest_in    : per-source destination (register number or store address)
//   cdb_valid_out  : a broadcast is present this cycle
//   cdb_rob_ix_out : broadcast ROB tag
//   cdb_value_out  : broadcast value
//   cdb_dest_out   : broadcast destination
//   cdb_src_out    : index of the granted source
module cdb_arbiter
  import riscalar_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int ROB_IX_W   = riscalar_pkg::ROB_IX_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              flush_in,
  input  logic [NUM_SRC-1:0]                src_valid_in,
  output logic [NUM_SRC-1:0]                src_ready_out,
  input  logic [NUM_SRC-1:0][ROB_IX_W-1:0]  src_rob_ix_in,
  input  logic [NUM_SRC-1:0][31:0]          src_value_in,
  input  logic [NUM_SRC-1:0][31:0]          src_dest_in,
  output logic                              cdb_valid_out,
  output logic [ROB_IX_W-1:0]               cdb_rob_ix_out,
  output logic signed [31:0]                cdb_value_out,
  output logic signed [31:0]                cdb_dest_out,
  output logic [$clog2(NUM_SRC)-1:0]        cdb_src_out
);

  localparam int SRC_W = $clog2(NUM_SRC);

  cdb_entry_t         in_entry [NUM_SRC];
  cdb_entry_t         head     [NUM_SRC];
  logic [NUM_SRC-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;

  logic               gnt_valid;
  logic [SRC_W-1:0]   gnt_ix;
  int                 cand;

  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  cdb_entry_t         cdb_entry_q, cdb_entry_d;
  logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign in_entry[g].rob_ix = src_rob_ix_in[g];
    assign in_entry[g].value  = src_value_in[g];
    assign in_entry[g].dest   = src_dest_in[g];

    assign src_ready_out[g] = !fifo_full[g] && !rst_in;
    assign fifo_push[g]     = src_valid_in[g] && src_ready_out[g] && !flush_in;
    assign fifo_pop[g]      = gnt_valid && (gnt_ix == SRC_W'(g)) && !flush_in;

    cdb_src_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .flush_in  (flush_in),
      .push_in   (fifo_push[g]),
      .pop_in    (fifo_pop[g]),
      .data_in   (in_entry[g]),
      .data_out  (head[g]),
      .full_out  (fifo_full[g]),
      .empty_out (fifo_empty[g])
    );
  end

  // Round-robin: scan upward from rr_ptr and wrap. The first non-empty
  // FIFO wins. Requests come from registered counts, so a result pushed
  // on this edge can be granted no earlier than the next edge.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_ix    = '0;
    cand      = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_SRC;
      if (!gnt_valid && !fifo_empty[cand]) begin
        gnt_valid = 1'b1;
        gnt_ix    = SRC_W'(cand);
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_entry_d = cdb_entry_q;
    cdb_src_d   = cdb_src_q;
    if (flush_in) begin
      // The data registers hold. Only valid and the pointer are cleared.
      rr_ptr_d = '0;
    end else if (gnt_valid) begin
      rr_ptr_d    = SRC_W'((int'(gnt_ix) + 1) % NUM_SRC);
      cdb_valid_d = 1'b1;
      cdb_entry_d = head[gnt_ix];
      cdb_src_d   = gnt_ix;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_entry_q <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_entry_q <= cdb_entry_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid_out  = cdb_valid_q;
  assign cdb_rob_ix_out = cdb_entry_q.rob_ix;
  assign cdb_value_out  = cdb_entry_q.value;
  assign cdb_dest_out   = cdb_entry_q.dest;
  assign cdb_src_out    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int RW = 3;
  localparam int D  = 2;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic                     flush_in;
  logic [N-1:0]             src_valid_in;
  logic [N-1:0]             src_ready_out;
  logic [N-1:0][RW-1:0]     src_rob_ix_in;
  logic [N-1:0][31:0]       src_value_in;
  logic [N-1:0][31:0]       src_dest_in;
  logic                     cdb_valid_out;
  logic [RW-1:0]            cdb_rob_ix_out;
  logic [31:0]              cdb_value_out;
  logic [31:0]              cdb_dest_out;
  logic [1:0]               cdb_src_out;

  cdb_arbiter #(.NUM_SRC(N), .ROB_IX_W(RW), .FIFO_DEPTH(D)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .flush_in       (flush_in),
    .src_valid_in   (src_valid_in),
    .src_ready_out  (src_ready_out),
    .src_rob_ix_in  (src_rob_ix_in),
    .src_value_in   (src_value_in),
    .src_dest_in    (src_dest_in),
    .cdb_valid_out  (cdb_valid_out),
    .cdb_rob_ix_out (cdb_rob_ix_out),
    .cdb_value_out  (cdb_value_out),
    .cdb_dest_out   (cdb_dest_out),
    .cdb_src_out    (cdb_src_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per source, and a round-robin pointer kept as an integer.
  typedef struct {
    logic [RW-1:0] rob;
    logic [31:0]   val;
    logic [31:0]   dst;
  } ent_t;

  ent_t        mq[N][$];
  int          m_rr = 0;
  logic        m_valid = 1'b0;
  logic [RW-1:0] m_rob = '0;
  logic [31:0] m_val = '0, m_dst = '0;
  logic [1:0]  m_src = '0;
  bit          started = 0;
  logic [31:0] bq[$];

  always @(posedge clk_in) begin : model
    int   g;
    int   idx;
    bit   acc [N];
    ent_t e;
    if (rst_in) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr = 0; m_valid = 0; m_rob = '0; m_val = '0; m_dst = '0; m_src = '0;
    end else if (flush_in) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr = 0; m_valid = 0;
    end else begin
      for (int i = 0; i < N; i++) acc[i] = src_valid_in[i] && (mq[i].size() < D);
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      if (g >= 0) begin
        e = mq[g].pop_front();
        m_valid = 1; m_rob = e.rob; m_val = e.val; m_dst = e.dst;
        m_src = 2'(g); m_rr = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
      for (int i = 0; i < N; i++)
        if (acc[i]) mq[i].push_back('{src_rob_ix_in[i], src_value_in[i], src_dest_in[i]});
    end
    started = 1;
  end

  always @(negedge clk_in) begin : compare
    logic [N-1:0] exp_rdy;
    if (started) begin
      for (int i = 0; i < N; i++) exp_rdy[i] = !rst_in && (mq[i].size() < D);
      chk("m_valid",  64'(cdb_valid_out),  64'(m_valid));
      chk("m_rob_ix", 64'(cdb_rob_ix_out), 64'(m_rob));
      chk("m_value",  64'(cdb_value_out),  64'(m_val));
      chk("m_dest",   64'(cdb_dest_out),   64'(m_dst));
      chk("m_src",    64'(cdb_src_out),    64'(m_src));
      chk("m_ready",  64'(src_ready_out),  64'(exp_rdy));
      if (cdb_valid_out) bq.push_back(cdb_value_out);
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #2;
  endtask

  initial begin
    int acc0;
    int v0;
    bit saw_low;
    bit rdy0;
    logic [31:0] exp_bp [8];

    rst_in = 1; flush_in = 0; src_valid_in = 4'b1111;
    for (int i = 0; i < N; i++) begin
      src_rob_ix_in[i] = RW'(i + 1); src_value_in[i] = 32'(i + 50); src_dest_in[i] = 32'(i + 60);
    end
    cyc(); cyc();
    chk("rst_ready", 64'(src_ready_out), 64'd0);
    chk("rst_valid", 64'(cdb_valid_out), 64'd0);
    chk("rst_rob",   64'(cdb_rob_ix_out), 64'd0);
    chk("rst_value", 64'(cdb_value_out), 64'd0);
    chk("rst_dest",  64'(cdb_dest_out), 64'd0);
    chk("rst_src",   64'(cdb_src_out), 64'd0);
    rst_in = 0; src_valid_in = '0;
    #1 chk("post_rst_ready", 64'(src_ready_out), 64'hF);

    // Single-source latency
    src_valid_in = 4'b0100;
    src_rob_ix_in[2] = 3'd5; src_value_in[2] = 32'hFFFF_FFF9; src_dest_in[2] = 32'd3;
    cyc();
    src_valid_in = '0;
    cyc();
    chk("lat_valid", 64'(cdb_valid_out), 64'd1);
    chk("lat_rob",   64'(cdb_rob_ix_out), 64'd5);
    chk("lat_value", 64'(cdb_value_out), 64'hFFFF_FFF9);
    chk("lat_dest",  64'(cdb_dest_out), 64'd3);
    chk("lat_src",   64'(cdb_src_out), 64'd2);
    cyc();
    chk("lat_idle", 64'(cdb_valid_out), 64'd0);

    // Flush returns the round-robin pointer to 0 so the sweep starts at source 0.
    flush_in = 1; cyc(); flush_in = 0;

    // Round-robin sweep, run twice
    for (int r = 0; r < 2; r++) begin
      src_valid_in = 4'b1111;
      for (int i = 0; i < N; i++) begin
        src_rob_ix_in[i] = RW'(i); src_value_in[i] = 32'(i + 8); src_dest_in[i] = 32'(i);
      end
      cyc();
      src_valid_in = '0;
      for (int k = 0; k < N; k++) begin
        cyc();
        chk("rr_valid", 64'(cdb_valid_out), 64'd1);
        chk("rr_src",   64'(cdb_src_out), 64'(k));
        chk("rr_value", 64'(cdb_value_out), 64'(k + 8));
        chk("rr_rob",   64'(cdb_rob_ix_out), 64'(k));
      end
      cyc();
      chk("rr_idle", 64'(cdb_valid_out), 64'd0);
    end

    // Backpressure: source 0 streams while sources 1-3 each have one result pending.
    bq.delete();
    acc0 = 0; v0 = 100; saw_low = 0;
    src_valid_in = 4'b1111;
    for (int i = 0; i < N; i++) begin
      src_rob_ix_in[i] = RW'(i); src_dest_in[i] = 32'(i);
      src_value_in[i] = (i == 0) ? 32'(v0) : 32'(200 + i);
    end
    for (int c = 0; c < 40 && acc0 < 5; c++) begin
      rdy0 = src_ready_out[0];
      if (!rdy0) saw_low = 1;
      cyc();
      src_valid_in[3:1] = '0;
      if (rdy0) begin
        acc0++; v0++;
        src_value_in[0] = 32'(v0);
        if (acc0 == 5) src_valid_in[0] = 1'b0;
      end
    end
    chk("bp_accepted", 64'(acc0), 64'd5);
    repeat (8) cyc();
    chk("bp_ready_dropped", 64'(saw_low), 64'd1);
    chk("bp_count", 64'(bq.size()), 64'd8);
    bq.sort();
    exp_bp = '{32'd100, 32'd101, 32'd102, 32'd103, 32'd104, 32'd201, 32'd202, 32'd203};
    for (int i = 0; i < 8; i++)
      if (i < bq.size()) chk("bp_value", 64'(bq[i]), 64'(exp_bp[i]));

    // Flush with results buffered, plus a push on the flush edge
    src_valid_in = 4'b0111;
    for (int i = 0; i < N; i++) src_value_in[i] = 32'(300 + i);
    cyc();
    src_valid_in = 4'b0010; src_value_in[1] = 32'd399; flush_in = 1;
    cyc();
    src_valid_in = '0; flush_in = 0;
    chk("fl_valid", 64'(cdb_valid_out), 64'd0);
    chk("fl_ready", 64'(src_ready_out), 64'hF);
    bq.delete();
    repeat (3) cyc();
    chk("fl_quiet", 64'(bq.size()), 64'd0);

    // Wrap: source 3 streams 8 values
    bq.delete();
    for (int k = 0; k < 10; k++) begin
      src_valid_in = (k < 8) ? 4'b1000 : 4'b0000;
      src_rob_ix_in[3] = RW'(k); src_value_in[3] = 32'(8 + k); src_dest_in[3] = 32'(k);
      cyc();
      if (k >= 1 && k <= 8) begin
        chk("wr_valid", 64'(cdb_valid_out), 64'd1);
        chk("wr_value", 64'(cdb_value_out), 64'(8 + k - 1));
      end else if (k == 9) begin
        chk("wr_idle", 64'(cdb_valid_out), 64'd0);
      end
    end
    chk("wr_count", 64'(bq.size()), 64'd8);

    // Reset while a result is buffered
    src_valid_in = 4'b0001; src_value_in[0] = 32'd500; src_rob_ix_in[0] = 3'd6;
    cyc();
    src_valid_in = '0; rst_in = 1;
    cyc();
    rst_in = 0;
    chk("mr_valid", 64'(cdb_valid_out), 64'd0);
    chk("mr_value", 64'(cdb_value_out), 64'd0);
    cyc();
    chk("mr_idle", 64'(cdb_valid_out), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Producer side of the common data bus (CDB). Collects completed results from NUM_SRC functional units through per-source valid/ready handshakes and buffers each source in a small FIFO. Every cycle it grants one buffered result by round-robin and broadcasts it on a registered CDB port that drives the reorder buffer's `cdb_*` inputs and the reservation stations. Sits between the execute units and the ROB.

## Interface
- NUM_SRC, 4: number of functional-unit result sources (≥2).
- ROB_IX_W, 3: ROB index width (ROB SIZE 8).
- FIFO_DEPTH, 2: entries per source FIFO (power of two, ≥2).
- clk_in  input  1  system clock; all state updates on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- flush_in  input  1  squash all buffered results (mispredict recovery).
- src_valid_in  input  [NUM_SRC-1:0]  source i presents a result.
- src_ready_out  output  [NUM_SRC-1:0]  source i FIFO can accept.
- src_rob_ix_in  input  [NUM_SRC-1:0][ROB_IX_W-1:0]  ROB tag of result.
- src_value_in  input  [NUM_SRC-1:0][31:0] signed  result value.
- src_dest_in  input  [NUM_SRC-1:0][31:0] signed  destination (register number or store address).
- cdb_valid_out  output  1  broadcast valid this cycle.
- cdb_rob_ix_out  output  ROB_IX_W  broadcast ROB tag.
- cdb_value_out  output  32 signed  broadcast value.
- cdb_dest_out  output  32 signed  broadcast destination.
- cdb_src_out  output  $clog2(NUM_SRC)  granted source index (debug/perf).

## Operation
- Accept: source i pushes on a rising edge where src_valid_in[i] && src_ready_out[i] && !flush_in && !rst_in.
- src_ready_out[i] = (count[i] < FIFO_DEPTH) && !rst_in; it depends only on registered count, never on src_valid_in or the grant.
- Arbitration: request[i] = FIFO i non-empty (registered state only; a result pushed this edge is not eligible until the next cycle). Grant the lowest i ≥ rr_ptr among requesters, wrapping modulo NUM_SRC. On a grant, pop head of FIFO i and set rr_ptr = (i+1) mod NUM_SRC. With no requesters, rr_ptr holds.
- Broadcast registers: on a grant, load the popped entry into cdb_rob_ix/value/dest_out, cdb_src_out = i, and cdb_valid_out = 1. Otherwise cdb_valid_out = 0 and the data registers hold their last value.
- Simultaneous push and pop on a full FIFO: the pop frees a slot only from the next cycle, so ready stays 0 for that edge. Push and pop on a non-full FIFO both take effect; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. The count register is $clog2(FIFO_DEPTH)+1 bits wide.
- Flush: on an edge with flush_in=1, all FIFOs empty (count, rd/wr pointers = 0), rr_ptr = 0, and cdb_valid_out = 0. Any push or grant on that edge is discarded. The data registers hold.
- Reset: identical to flush. In addition, cdb_rob_ix_out, cdb_value_out, cdb_dest_out and cdb_src_out clear to 0. Reset takes priority over flush.
- The block does no tag checking; the ROB owns duplicate and ordering semantics.

## Timing
- Reset values: cdb_valid_out=0, cdb_rob_ix_out=0, cdb_value_out=0, cdb_dest_out=0, cdb_src_out=0. src_ready_out=0 while rst_in is high and all 1s in the first cycle after.
- Latency: a result accepted at edge N into an empty, uncontended FIFO is eligible for grant at edge N+1 and visible on the CDB during cycle N+1→N+2. Minimum latency is 2 edges, valid-in to cdb_valid_out.
- Throughput: 1 broadcast per cycle total. A single uncontended source sustains 1 accept per cycle with FIFO_DEPTH=2.
- Fairness: with K sources continuously requesting, each is granted exactly once every K cycles.
- A mid-operation reset or flush drops all buffered results; nothing is broadcast on the following cycle.

## Structure
- Shared package `riscalar_pkg`:
  - `cdb_entry_t` struct {rob_ix, value, dest}, shared with rob and the reservation stations.
  - ROB_IX_W default.
- Sub-module `cdb_src_fifo`: one per source via generate. It is a parameterised sync FIFO of `cdb_entry_t` with push/pop/flush, count, full and empty.
- Round-robin grant logic stays inline in `cdb_arbiter`.

## Test plan
- Reset: hold rst_in 2 cycles with src_valid_in=4'b1111 → no broadcast; all CDB outputs are 0; src_ready_out=0 during reset and 4'b1111 after.
- Single source latency: source 2 pushes {rob_ix=5, value=-7, dest=3} at edge N → cdb_valid_out=1, rob_ix=5, value=-7, dest=3, src=2 in cycle after edge N+1; valid=0 on the next cycle.
- Round-robin: all 4 sources push one result each (rob_ix=i, value=i+8) on the same edge → four consecutive broadcasts with src 0,1,2,3, then valid=0. Repeat → order resumes at src 0.
- Backpressure: source 0 pushes every cycle while sources 1–3 each keep one result pending → FIFO 0 fills and src_ready_out[0] drops. Broadcasts alternate fairly, with no loss or duplication of the 8 values pushed.
- Flush mid-stream: 3 results buffered, flush_in pulsed with a simultaneous push on source 1 → cdb_valid_out=0 next cycle, nothing further broadcast, src_ready_out all 1s.
- Wrap: a single source streams 8 results (values 8..15) at 1/cycle → 8 consecutive broadcasts in order, with FIFO pointers wrapping cleanly.
